hazard_scoreboard_ctrl: RTL and testbench

// Pipeline sequencer for the decode stage: per-register scoreboard of in-flight writebacks plus a

---
 rtl/hazard_scoreboard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage sequencer: per-register writeback scoreboard plus SR pending count,
// gating ID->EX issue on RAW/SR hazards, memory wait and taken-branch flushes.

module hsb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic nz,
    output logic full
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt;

    // Simultaneous inc/dec nets to zero; dec at 0 and inc at MAX both hold.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (inc && !dec && cnt != MAX)
            cnt <= cnt + CNT_W'(1);
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign nz   = (cnt != '0);
    assign full = (cnt == MAX);
endmodule

module hazard_scoreboard_ctrl #(
    parameter int CNT_W     = 2,
    parameter int FLUSH_CYC = 1,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_src1,
    input  logic              id_src1_used,
    input  logic [3:0]        id_src2,
    input  logic              id_src2_used,
    input  logic              id_wb_en,
    input  logic [3:0]        id_dest,
    input  logic              id_s,
    input  logic              id_cond_sr,
    input  logic              wb_wb_en,
    input  logic [3:0]        wb_dest,
    input  logic              sr_retire,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              freeze,
    output logic              flush,
    output logic              issue,
    output logic [15:0]       pend_map,
    output logic              sr_pending,
    output logic [PERF_W-1:0] stall_cycles
);
    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYC - 1);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_FLUSH   = 2'd1;
    localparam logic [1:0] S_MEMWAIT = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
    logic [15:0]     full_map;
    logic            sr_full;
    logic            haz;
    logic            frz_c, flush_c, issue_c;

    for (genvar r = 0; r < 16; r++) begin : g_reg
        hsb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (issue & id_wb_en & (id_dest == 4'(r))),
            .dec  (wb_wb_en & (wb_dest == 4'(r))),
            .nz   (pend_map[r]),
            .full (full_map[r])
        );
    end

    hsb_cnt #(.CNT_W(CNT_W)) u_sr_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (issue & id_s),
        .dec  (sr_retire),
        .nz   (sr_pending),
        .full (sr_full)
    );

    // Registered counts only: a WB landing this cycle does not clear the hazard until next cycle.
    assign haz = id_valid & ((id_src1_used & pend_map[id_src1])
                           | (id_src2_used & pend_map[id_src2])
                           | (id_cond_sr   & sr_pending)
                           | (id_wb_en     & full_map[id_dest])
                           | (id_s         & sr_full));

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        frz_c         = 1'b0;
        flush_c       = 1'b0;
        issue_c       = 1'b0;
        if (branch_taken) begin
            flush_c       = 1'b1;
            flush_cnt_nxt = FLUSH_RELOAD;
            state_nxt     = (FLUSH_CYC == 1) ? S_RUN : S_FLUSH;
        end else if (state == S_FLUSH) begin
            // The branch cycle itself was the first flush cycle.
            flush_c       = 1'b1;
            flush_cnt_nxt = flush_cnt - FC_W'(1);
            if (flush_cnt <= FC_W'(1))
                state_nxt = S_RUN;
        end else if (mem_busy) begin
            frz_c     = 1'b1;
            state_nxt = S_MEMWAIT;
        end else begin
            frz_c     = haz;
            issue_c   = id_valid & ~haz;
            state_nxt = S_RUN;
        end
    end

    assign freeze = rst & frz_c;
    assign flush  = rst & flush_c;
    assign issue  = rst & issue_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_RUN;
            flush_cnt    <= '0;
            stall_cycles <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (freeze && stall_cycles != '1)
                stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench: stimulus pushes hand-computed expected outputs, a negedge monitor pops and compares.

module tb_hazard_scoreboard_ctrl;
    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [3:0] src1;
        logic       s1u;
        logic [3:0] src2;
        logic       s2u;
        logic       wb_en;
        logic [3:0] dest;
        logic       s;
        logic       cond_sr;
        logic       wbwb;
        logic [3:0] wbd;
        logic       sr_retire;
        logic       br;
        logic       mem;
    } vec_t;

    typedef struct packed {
        logic        fz;
        logic        fl;
        logic        is;
        logic [15:0] pm;
        logic        sp;
        logic [15:0] st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_src1_used, id_src2_used, id_wb_en, id_s, id_cond_sr;
    logic [3:0]  id_src1, id_src2, id_dest, wb_dest;
    logic        wb_wb_en, sr_retire, branch_taken, mem_busy;
    logic        freeze, flush, issue, sr_pending;
    logic [15:0] pend_map, stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard_ctrl #(.CNT_W(2), .FLUSH_CYC(2), .PERF_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_wb_en(id_wb_en), .id_dest(id_dest), .id_s(id_s), .id_cond_sr(id_cond_sr),
        .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .sr_retire(sr_retire),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .freeze(freeze), .flush(flush), .issue(issue),
        .pend_map(pend_map), .sr_pending(sr_pending), .stall_cycles(stall_cycles)
    );

    exp_t q[$];
    int   applied = 0;
    int   miscompares = 0;
    int   vec_idx = 0;
    vec_t v;

    function automatic vec_t idle();
        vec_t t = '0;
        t.rst = 1'b1;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        rst = t.rst; id_valid = t.id_valid;
        id_src1 = t.src1; id_src1_used = t.s1u; id_src2 = t.src2; id_src2_used = t.s2u;
        id_wb_en = t.wb_en; id_dest = t.dest; id_s = t.s; id_cond_sr = t.cond_sr;
        wb_wb_en = t.wbwb; wb_dest = t.wbd; sr_retire = t.sr_retire;
        branch_taken = t.br; mem_busy = t.mem;
    endtask

    task automatic step(input logic fz, fl, is, input logic [15:0] pm, input logic sp,
                        input logic [15:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v);
        e = '{fz: fz, fl: fl, is: is, pm: pm, sp: sp, st: st};
        q.push_back(e);
    endtask

    task automatic rand_reset();
        logic [31:0] r = $urandom;
        v = vec_t'(r[$bits(vec_t)-1:0]);
        v.rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        if (q.size() > 0) begin
            e = q.pop_front();
            g = '{fz: freeze, fl: flush, is: issue, pm: pend_map, sp: sr_pending, st: stall_cycles};
            applied++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL vec%0d fz/fl/is/pm/sp/st got %b %b %b %h %b %0d exp %b %b %b %h %b %0d",
                         vec_idx, g.fz, g.fl, g.is, g.pm, g.sp, g.st,
                         e.fz, e.fl, e.is, e.pm, e.sp, e.st);
            end
            vec_idx++;
        end
        // Stimulus must never retire something that is not in flight.
        if (rst === 1'b1 && ((wb_wb_en && !pend_map[wb_dest]) || (sr_retire && !sr_pending))) begin
            miscompares++;
            $display("FAIL protocol underflow at vec%0d", vec_idx);
        end
    end

    initial begin
        rand_reset();
        drive(v);
        // Reset with random inputs: outputs forced low, state cleared
        for (int i = 0; i < 3; i++) begin
            rand_reset();
            step(0, 0, 0, 16'h0000, 0, 0);
        end
        v = idle();                                             step(0, 0, 0, 16'h0000, 0, 0);
        // RAW on r3
        v = idle(); v.id_valid = 1; v.wb_en = 1; v.dest = 3;    step(0, 0, 1, 16'h0000, 0, 0);
        v = idle(); v.id_valid = 1; v.src1 = 3; v.s1u = 1;      step(1, 0, 0, 16'h0008, 0, 0);
        v.wbwb = 1; v.wbd = 3;                                  step(1, 0, 0, 16'h0008, 0, 1);
        v.wbwb = 0;                                             step(0, 0, 1, 16'h0000, 0, 2);
        // Same-cycle issue and WB on r5
        v = idle(); v.id_valid = 1; v.wb_en = 1; v.dest = 5;    step(0, 0, 1, 16'h0000, 0, 2);
        v.wbwb = 1; v.wbd = 5;                                  step(0, 0, 1, 16'h0020, 0, 2);
        v = idle(); v.wbwb = 1; v.wbd = 5;                      step(0, 0, 0, 16'h0020, 0, 2);
        // SR hazard, then an AL instruction with SR pending
        v = idle(); v.id_valid = 1; v.s = 1;                    step(0, 0, 1, 16'h0000, 0, 2);
        v = idle(); v.id_valid = 1; v.cond_sr = 1;              step(1, 0, 0, 16'h0000, 1, 2);
        v.sr_retire = 1;                                        step(1, 0, 0, 16'h0000, 1, 3);
        v.sr_retire = 0;                                        step(0, 0, 1, 16'h0000, 0, 4);
        v = idle(); v.id_valid = 1; v.s = 1;                    step(0, 0, 1, 16'h0000, 0, 4);
        v = idle(); v.id_valid = 1; v.sr_retire = 1;            step(0, 0, 1, 16'h0000, 1, 4);
        // Branch during MEMWAIT, FLUSH_CYC=2; flushed writer must not leak
        v = idle(); v.id_valid = 1; v.mem = 1;                  step(1, 0, 0, 16'h0000, 0, 4);
        step(1, 0, 0, 16'h0000, 0, 5);
        v.br = 1; v.wb_en = 1; v.dest = 9;                      step(0, 1, 0, 16'h0000, 0, 6);
        v.br = 0; v.mem = 0;                                    step(0, 1, 0, 16'h0000, 0, 6);
        v = idle(); v.id_valid = 1;                             step(0, 0, 1, 16'h0000, 0, 6);
        // Saturation on r7
        v = idle(); v.id_valid = 1; v.wb_en = 1; v.dest = 7;    step(0, 0, 1, 16'h0000, 0, 6);
        step(0, 0, 1, 16'h0080, 0, 6);
        step(0, 0, 1, 16'h0080, 0, 6);
        step(1, 0, 0, 16'h0080, 0, 6);
        v.wbwb = 1; v.wbd = 7;                                  step(1, 0, 0, 16'h0080, 0, 7);
        v.wbwb = 0;                                             step(0, 0, 1, 16'h0080, 0, 8);
        v = idle(); v.wbwb = 1; v.wbd = 7;                      step(0, 0, 0, 16'h0080, 0, 8);
        // MEMWAIT release applies RUN rules in the same cycle
        v = idle(); v.mem = 1;                                  step(1, 0, 0, 16'h0080, 0, 8);
        v = idle(); v.id_valid = 1; v.src1 = 7; v.s1u = 1;      step(1, 0, 0, 16'h0080, 0, 9);
        v = idle(); v.id_valid = 1; v.wb_en = 1; v.dest = 1;    step(0, 0, 1, 16'h0080, 0, 10);
        v = idle(); v.mem = 1;                                  step(1, 0, 0, 16'h0082, 0, 10);
        v = idle(); v.id_valid = 1;                             step(0, 0, 1, 16'h0082, 0, 11);
        // Mid-run reset
        rand_reset();                                           step(0, 0, 0, 16'h0082, 0, 11);
        v = idle();                                             step(0, 0, 0, 16'h0000, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain timeout, %0d expected outputs never checked", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
